// File: rtl/scanconv_pkg.sv
// Shared constants for the JAMMA scan converter: pixel format, line-buffer depth
// and the CGA/EGA active-window timing also used by the timing generator.
package scanconv_pkg;

    localparam int PIX_W      = 12;
    localparam int DEPTH_LOG2 = 9;

    localparam int H_START = 16;
    localparam int CGA_W   = 320;
    localparam int EGA_W   = 400;
    localparam int V_START = 8;
    localparam int V_ACT   = 200;

endpackage

// File: rtl/linebuf_ram.sv
// Simple dual-port synchronous RAM holding both line-buffer banks.
// The bank is the top address bit; read data is registered (1-cycle latency).
module linebuf_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/scanconv_linebuf.sv
// Ping-pong scan-doubling line buffer: captures one input line into the write
// bank while replaying the other bank against the output ha/va timing.
module scanconv_linebuf
    import scanconv_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] in_pix,
    input  logic             in_pix_valid,
    input  logic             in_line_start,
    input  logic [8:0]       ha,
    input  logic [7:0]       va,
    input  logic             egamode,
    output logic [PIX_W-1:0] out_rgb,
    output logic             out_blank,
    output logic             ovf
);

    localparam int PTR_W = DEPTH_LOG2 + 1;

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [8:0]       H_START_C = 9'(H_START);
    localparam logic [9:0]       CGA_W_C   = 10'(CGA_W);
    localparam logic [9:0]       EGA_W_C   = 10'(EGA_W);
    localparam logic [7:0]       V_START_C = 8'(V_START);
    localparam logic [7:0]       V_END_C   = 8'(V_START + V_ACT);

    logic                   wbank_q, wbank_d;
    logic [PTR_W-1:0]       wptr_q, wptr_d;
    logic [1:0][PTR_W-1:0]  len_q, len_d;
    logic                   ovf_q, ovf_d;

    logic                   wrEn;
    logic                   wrBank;
    logic [DEPTH_LOG2-1:0]  wrAddr;

    logic [8:0]             x;
    logic [9:0]             actWidth;
    logic                   hact0, vact0, inLen0, rdBank;
    logic [PIX_W-1:0]       ramData;

    logic                   hact1_q, vact1_q, inLen1_q;
    logic [PIX_W-1:0]       rgb_q, rgb_d;
    logic                   blank_q, blank_d;

    // A pixel arriving with the swap pulse is the first pixel of the new line,
    // so it lands at address 0 of the bank that is about to become the write bank.
    always_comb begin
        wbank_d = wbank_q;
        wptr_d  = wptr_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        wrEn    = 1'b0;
        wrBank  = wbank_q;
        wrAddr  = wptr_q[DEPTH_LOG2-1:0];
        if (in_line_start) begin
            len_d[wbank_q] = wptr_q;
            wbank_d        = ~wbank_q;
            wptr_d         = '0;
            if (in_pix_valid) begin
                wrEn   = 1'b1;
                wrBank = ~wbank_q;
                wrAddr = '0;
                wptr_d = PTR_ONE;
            end
        end else if (in_pix_valid) begin
            if (!wptr_q[DEPTH_LOG2]) begin
                wrEn   = 1'b1;
                wptr_d = wptr_q + PTR_ONE;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wbank_q <= 1'b0;
            wptr_q  <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wbank_q <= wbank_d;
            wptr_q  <= wptr_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        x        = ha - H_START_C;
        actWidth = egamode ? EGA_W_C : CGA_W_C;
        hact0    = (ha >= H_START_C) && ({1'b0, x} < actWidth);
        vact0    = (va >= V_START_C) && (va < V_END_C);
        rdBank   = ~wbank_q;
        inLen0   = {1'b0, x} < len_q[rdBank];
    end

    linebuf_ram #(
        .ADDR_W(DEPTH_LOG2 + 1),
        .DATA_W(PIX_W)
    ) u_ram (
        .clk    (clk),
        .we_i   (wrEn),
        .waddr_i({wrBank, wrAddr}),
        .wdata_i(in_pix),
        .raddr_i({rdBank, x}),
        .rdata_o(ramData)
    );

    // Beyond the stored length the line stays active but is shown black.
    always_comb begin
        blank_d = ~(hact1_q & vact1_q);
        rgb_d   = (hact1_q & vact1_q & inLen1_q) ? ramData : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hact1_q  <= 1'b0;
            vact1_q  <= 1'b0;
            inLen1_q <= 1'b0;
            rgb_q    <= '0;
            blank_q  <= 1'b1;
        end else begin
            hact1_q  <= hact0;
            vact1_q  <= vact0;
            inLen1_q <= inLen0;
            rgb_q    <= rgb_d;
            blank_q  <= blank_d;
        end
    end

    assign out_rgb   = rgb_q;
    assign out_blank = blank_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_scanconv_linebuf.sv
// Directed bench for scanconv_linebuf: capture/replay, short and empty lines,
// overflow, swap-with-pixel, vertical blank and asynchronous reset.
module tb_scanconv_linebuf;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] in_pix;
    logic        in_pix_valid;
    logic        in_line_start;
    logic [8:0]  ha;
    logic [7:0]  va;
    logic        egamode;
    logic [11:0] out_rgb;
    logic        out_blank;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    // Expected buffer contents, tracked alongside the stimulus.
    logic [11:0] refMem [2][512];
    int          refLen [2];
    int          refWb;
    int          refWptr;

    always #5 clk = ~clk;

    scanconv_linebuf dut (
        .clk          (clk),
        .reset        (reset),
        .in_pix       (in_pix),
        .in_pix_valid (in_pix_valid),
        .in_line_start(in_line_start),
        .ha           (ha),
        .va           (va),
        .egamode      (egamode),
        .out_rgb      (out_rgb),
        .out_blank    (out_blank),
        .ovf          (ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushPixels(input int n, input int base, input bit incr);
        for (int i = 0; i < n; i++) begin
            logic [11:0] p;
            p            = 12'(incr ? base + i : base);
            in_pix       = p;
            in_pix_valid = 1'b1;
            if (refWptr < 512) begin
                refMem[refWb][refWptr] = p;
                refWptr++;
            end
            tick();
        end
        in_pix_valid = 1'b0;
    endtask

    task automatic swapLine(input bit withPix, input logic [11:0] pix);
        in_line_start  = 1'b1;
        in_pix_valid   = withPix;
        in_pix         = pix;
        refLen[refWb]  = refWptr;
        refWb          = 1 - refWb;
        refWptr        = 0;
        if (withPix) begin
            refMem[refWb][0] = pix;
            refWptr          = 1;
        end
        tick();
        in_line_start = 1'b0;
        in_pix_valid  = 1'b0;
    endtask

    // Output seen while ha=h is driven belongs to ha=h-2 (two-clock latency).
    function automatic logic [12:0] expOut(input int h, input int v, input bit ega);
        int hs, x, w, rb;
        expOut = {1'b1, 12'h000};
        hs = h - 2;
        x  = hs - 16;
        w  = ega ? 400 : 320;
        rb = 1 - refWb;
        if (h >= 2 && hs >= 16 && x < w && v >= 8 && v < 208) begin
            expOut[12] = 1'b0;
            if (x < refLen[rb]) expOut[11:0] = refMem[rb][x];
        end
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (out_blank !== 1'b1 || out_rgb !== 12'h000 || ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state got blank=%0b rgb=%h ovf=%0b expected blank=1 rgb=000 ovf=0",
                     out_blank, out_rgb, ovf);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_swap_replay();
        logic [12:0] e;
        egamode = 1'b0;
        pushPixels(320, 0, 1'b1);
        swapLine(1'b0, 12'h000);
        va = 8'd8;
        for (int h = 0; h < 512; h++) begin
            ha = 9'(h);
            @(negedge clk);
            e = expOut(h, 8, 1'b0);
            checks++;
            if ({out_blank, out_rgb} !== e) begin
                errors++;
                $display("[TB] FAIL swap_replay ha=%0d got blank=%0b rgb=%h expected blank=%0b rgb=%h",
                         h, out_blank, out_rgb, e[12], e[11:0]);
            end
            tick();
        end
        ha = 9'd0;
    endtask

    task automatic test_short_empty();
        logic [12:0] e;
        egamode = 1'b0;
        pushPixels(100, 12'hABC, 1'b0);
        swapLine(1'b0, 12'h000);
        va = 8'd20;
        for (int h = 0; h < 512; h++) begin
            ha = 9'(h);
            @(negedge clk);
            e = expOut(h, 20, 1'b0);
            checks++;
            if ({out_blank, out_rgb} !== e) begin
                errors++;
                $display("[TB] FAIL short_line ha=%0d got blank=%0b rgb=%h expected blank=%0b rgb=%h",
                         h, out_blank, out_rgb, e[12], e[11:0]);
            end
            tick();
        end
        ha = 9'd0;
        swapLine(1'b0, 12'h000);
        for (int h = 0; h < 512; h++) begin
            ha = 9'(h);
            @(negedge clk);
            e = expOut(h, 20, 1'b0);
            checks++;
            if ({out_blank, out_rgb} !== e) begin
                errors++;
                $display("[TB] FAIL empty_line ha=%0d got blank=%0b rgb=%h expected blank=%0b rgb=%h",
                         h, out_blank, out_rgb, e[12], e[11:0]);
            end
            tick();
        end
        ha = 9'd0;
    endtask

    task automatic test_overflow();
        logic [12:0] e;
        egamode = 1'b1;
        pushPixels(512, 0, 1'b1);
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_at_512 got %0b expected 0", ovf);
        end
        pushPixels(1, 512, 1'b1);
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_at_513 got %0b expected 1", ovf);
        end
        pushPixels(87, 513, 1'b1);
        swapLine(1'b0, 12'h000);
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_sticky_swap got %0b expected 1", ovf);
        end
        va = 8'd100;
        for (int h = 0; h < 512; h++) begin
            ha = 9'(h);
            @(negedge clk);
            e = expOut(h, 100, 1'b1);
            checks++;
            if ({out_blank, out_rgb} !== e) begin
                errors++;
                $display("[TB] FAIL overflow_ega ha=%0d got blank=%0b rgb=%h expected blank=%0b rgb=%h",
                         h, out_blank, out_rgb, e[12], e[11:0]);
            end
            tick();
        end
        ha = 9'd0;
    endtask

    task automatic test_simultaneous();
        logic [12:0] e;
        egamode = 1'b0;
        swapLine(1'b1, 12'h123);
        swapLine(1'b0, 12'h000);
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_sticky_later got %0b expected 1", ovf);
        end
        va = 8'd50;
        for (int h = 0; h < 512; h++) begin
            ha = 9'(h);
            @(negedge clk);
            e = expOut(h, 50, 1'b0);
            checks++;
            if ({out_blank, out_rgb} !== e) begin
                errors++;
                $display("[TB] FAIL simultaneous ha=%0d got blank=%0b rgb=%h expected blank=%0b rgb=%h",
                         h, out_blank, out_rgb, e[12], e[11:0]);
            end
            tick();
        end
        ha = 9'd0;
    endtask

    task automatic test_vblank();
        logic [12:0] e;
        int vList [3];
        vList   = '{7, 208, 207};
        egamode = 1'b0;
        pushPixels(320, 5, 1'b1);
        swapLine(1'b0, 12'h000);
        foreach (vList[k]) begin
            va = 8'(vList[k]);
            for (int h = 0; h < 512; h++) begin
                ha = 9'(h);
                @(negedge clk);
                e = expOut(h, vList[k], 1'b0);
                checks++;
                if ({out_blank, out_rgb} !== e) begin
                    errors++;
                    $display("[TB] FAIL vblank va=%0d ha=%0d got blank=%0b rgb=%h expected blank=%0b rgb=%h",
                             vList[k], h, out_blank, out_rgb, e[12], e[11:0]);
                end
                tick();
            end
            ha = 9'd0;
        end
    endtask

    task automatic test_async_reset();
        logic [12:0] e;
        egamode = 1'b0;
        pushPixels(320, 12'h040, 1'b1);
        swapLine(1'b0, 12'h000);
        va = 8'd8;
        for (int h = 0; h < 100; h++) begin
            ha = 9'(h);
            tick();
        end
        checks++;
        if (out_blank !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pre_reset_active got blank=%0b expected 0", out_blank);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_blank !== 1'b1 || out_rgb !== 12'h000 || ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset got blank=%0b rgb=%h ovf=%0b expected blank=1 rgb=000 ovf=0",
                     out_blank, out_rgb, ovf);
        end
        ha      = 9'd0;
        refWb   = 0;
        refWptr = 0;
        refLen  = '{0, 0};
        @(negedge clk);
        reset = 1'b1;
        tick();
        pushPixels(10, 12'h200, 1'b1);
        swapLine(1'b0, 12'h000);
        for (int h = 0; h < 512; h++) begin
            ha = 9'(h);
            @(negedge clk);
            e = expOut(h, 8, 1'b0);
            checks++;
            if ({out_blank, out_rgb} !== e) begin
                errors++;
                $display("[TB] FAIL after_reset ha=%0d got blank=%0b rgb=%h expected blank=%0b rgb=%h",
                         h, out_blank, out_rgb, e[12], e[11:0]);
            end
            tick();
        end
        ha = 9'd0;
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_after_reset got %0b expected 0", ovf);
        end
    endtask

    initial begin
        in_pix        = 12'h000;
        in_pix_valid  = 1'b0;
        in_line_start = 1'b0;
        ha            = 9'd0;
        va            = 8'd0;
        egamode       = 1'b0;
        refWb         = 0;
        refWptr       = 0;
        refLen        = '{0, 0};

        test_reset();
        test_swap_replay();
        test_short_empty();
        test_overflow();
        test_simultaneous();
        test_vblank();
        test_async_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
